cci_afu_rd_engine: RTL and testbench

CCI_AFU_RD_ENGINE -- requirements
Module: cci_afu_rd_engine

---
 rtl/cci_afu_rd_engine.sv | 137 +++++++++++++
 tb/tb_cci_afu_rd_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_afu_rd_engine.sv
// cci_afu_rd_engine: CSR-programmed AFU that streams N cache-line reads and then writes a status line.
//   vl_clk_LPdomain_32ui              - sole clock, rising edge
//   ffs_vl_LP32ui_lp2sy_SystemReset_n - synchronous active-low reset
//   ffs_vl_LP32ui_lp2sy_InitDnForSys  - link ready; TX requests held off while low
//   C0Rx{Hdr,Data,RdValid,WrValid,CgValid}, C1RxWrValid - responses and CSR writes
//   C0TxAlmFull / C1TxAlmFull         - TX back-pressure
//   C0TxHdr/C0TxRdValid               - registered read requests
//   C1TxHdr/C1TxData/C1TxWrValid      - registered status write; C1TxIrValid tied low
// Optional: define CCI_RD_ENGINE_CKSUM_EN to XOR-fold every read line into status word [95:64].
module cci_afu_rd_engine (
    input  logic         vl_clk_LPdomain_32ui,
    input  logic         ffs_vl_LP32ui_lp2sy_SystemReset_n,
    input  logic         ffs_vl_LP32ui_lp2sy_InitDnForSys,
    input  logic [17:0]  ffs_vl18_LP32ui_lp2sy_C0RxHdr,
    input  logic [511:0] ffs_vl512_LP32ui_lp2sy_C0RxData,
    input  logic         ffs_vl_LP32ui_lp2sy_C0RxRdValid,
    input  logic         ffs_vl_LP32ui_lp2sy_C0RxWrValid,
    input  logic         ffs_vl_LP32ui_lp2sy_C0RxCgValid,
    input  logic         ffs_vl_LP32ui_lp2sy_C1RxWrValid,
    input  logic         ffs_vl_LP32ui_lp2sy_C0TxAlmFull,
    input  logic         ffs_vl_LP32ui_lp2sy_C1TxAlmFull,
    output logic [60:0]  ffs_vl61_LP32ui_sy2lp_C0TxHdr,
    output logic         ffs_vl_LP32ui_sy2lp_C0TxRdValid,
    output logic [60:0]  ffs_vl61_LP32ui_sy2lp_C1TxHdr,
    output logic [511:0] ffs_vl512_LP32ui_sy2lp_C1TxData,
    output logic         ffs_vl_LP32ui_sy2lp_C1TxWrValid,
    output logic         ffs_vl_LP32ui_sy2lp_C1TxIrValid
);
    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRSTAT, WAITWR, DONE} state_t;

    state_t      state;
    logic        rst_n, init;
    logic [13:0] rx_addr;
    logic [31:0] rx_val;
    logic [31:0] csr_stat, csr_base, run_stat, run_base, cksum;
    logic [15:0] csr_n, run_n, issued, received;
    logic [5:0]  outstanding;
    logic        start, go, issue, rsp;
    logic        unused;

    assign rst_n   = ffs_vl_LP32ui_lp2sy_SystemReset_n;
    assign init    = ffs_vl_LP32ui_lp2sy_InitDnForSys;
    assign rx_addr = ffs_vl18_LP32ui_lp2sy_C0RxHdr[13:0];
    assign rx_val  = ffs_vl512_LP32ui_lp2sy_C0RxData[31:0];
    assign unused  = ^{ffs_vl18_LP32ui_lp2sy_C0RxHdr[17:14], ffs_vl512_LP32ui_lp2sy_C0RxData[511:32]};

    assign ffs_vl_LP32ui_sy2lp_C1TxIrValid = 1'b0;

    assign start = ffs_vl_LP32ui_lp2sy_C0RxCgValid && rx_addr == 14'h0A3 && rx_val[0];
    // starts arriving mid-run are dropped so a run always completes with its latched parameters
    assign go    = start && (state == IDLE || state == DONE);
    assign issue = state == READ && init && !ffs_vl_LP32ui_lp2sy_C0TxAlmFull &&
                   outstanding < 6'd32 && issued != run_n;
    // responses outside an active run (e.g. stragglers after a reset) are discarded
    assign rsp   = ffs_vl_LP32ui_lp2sy_C0RxRdValid && (state == READ || state == DRAIN);

    function automatic logic [60:0] tx_hdr(input logic [3:0] t, input logic [31:0] a, input logic [13:0] m);
        return {5'b0, t, 6'b0, a, m};
    endfunction

`ifdef CCI_RD_ENGINE_CKSUM_EN
    logic [31:0] line_xor;
    always_comb begin
        line_xor = '0;
        for (int i = 0; i < 16; i++)
            line_xor = line_xor ^ ffs_vl512_LP32ui_lp2sy_C0RxData[32*i +: 32];
    end
    always_ff @(posedge vl_clk_LPdomain_32ui) begin
        if (!rst_n || go)
            cksum <= '0;
        else if (rsp)
            cksum <= cksum ^ line_xor;
    end
`else
    assign cksum = '0;
`endif

    always_ff @(posedge vl_clk_LPdomain_32ui) begin
        if (!rst_n) begin
            state                           <= IDLE;
            csr_stat                        <= '0;
            csr_base                        <= '0;
            csr_n                           <= '0;
            run_stat                        <= '0;
            run_base                        <= '0;
            run_n                           <= '0;
            issued                          <= '0;
            received                        <= '0;
            outstanding                     <= '0;
            ffs_vl_LP32ui_sy2lp_C0TxRdValid <= 1'b0;
            ffs_vl61_LP32ui_sy2lp_C0TxHdr   <= '0;
            ffs_vl_LP32ui_sy2lp_C1TxWrValid <= 1'b0;
            ffs_vl61_LP32ui_sy2lp_C1TxHdr   <= '0;
            ffs_vl512_LP32ui_sy2lp_C1TxData <= '0;
        end else begin
            ffs_vl_LP32ui_sy2lp_C0TxRdValid <= 1'b0;
            ffs_vl_LP32ui_sy2lp_C1TxWrValid <= 1'b0;
            if (ffs_vl_LP32ui_lp2sy_C0RxCgValid && rx_addr == 14'h0A0) csr_stat <= rx_val;
            if (ffs_vl_LP32ui_lp2sy_C0RxCgValid && rx_addr == 14'h0A1) csr_base <= rx_val;
            if (ffs_vl_LP32ui_lp2sy_C0RxCgValid && rx_addr == 14'h0A2) csr_n    <= rx_val[15:0];
            // simultaneous issue and response cancel out
            outstanding <= outstanding + {5'b0, issue} - {5'b0, rsp};
            if (rsp)
                received <= received + 16'd1;
            if (issue) begin
                ffs_vl_LP32ui_sy2lp_C0TxRdValid <= 1'b1;
                ffs_vl61_LP32ui_sy2lp_C0TxHdr   <= tx_hdr(4'h4, run_base + {16'b0, issued}, issued[13:0]);
                issued                          <= issued + 16'd1;
            end
            case (state)
                IDLE, DONE: if (go) begin
                    run_stat    <= csr_stat;
                    run_base    <= csr_base;
                    run_n       <= csr_n;
                    issued      <= '0;
                    received    <= '0;
                    outstanding <= '0;
                    state       <= csr_n == 16'd0 ? WRSTAT : READ;
                end
                READ:   if (issued == run_n) state <= DRAIN;
                DRAIN:  if (received == run_n) state <= WRSTAT;
                WRSTAT: if (init && !ffs_vl_LP32ui_lp2sy_C1TxAlmFull) begin
                    ffs_vl_LP32ui_sy2lp_C1TxWrValid <= 1'b1;
                    ffs_vl61_LP32ui_sy2lp_C1TxHdr   <= tx_hdr(4'h2, run_stat, 14'h3FFF);
                    ffs_vl512_LP32ui_sy2lp_C1TxData <= {416'b0, cksum, 16'b0, run_n, 32'd1};
                    state                           <= WAITWR;
                end
                WAITWR: if (ffs_vl_LP32ui_lp2sy_C0RxWrValid || ffs_vl_LP32ui_lp2sy_C1RxWrValid) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge vl_clk_LPdomain_32ui)
        if (rst_n)
            assert (received <= issued && outstanding <= 6'd32);
endmodule

// File: tb/tb_cci_afu_rd_engine.sv
// tb_cci_afu_rd_engine: table-driven runs plus directed corner sequences for cci_afu_rd_engine.
module tb_cci_afu_rd_engine;
    localparam logic [13:0] A_STAT = 14'h0A0, A_BASE = 14'h0A1, A_N = 14'h0A2, A_CTL = 14'h0A3;

    typedef struct {
        logic [31:0] base;
        logic [31:0] stat;
        logic [15:0] n;
        logic [31:0] pat;
        logic [31:0] ck;
    } vec_t;

    logic         clk = 1'b0, rst_n = 1'b0, init = 1'b1;
    logic [17:0]  rx_hdr = '0;
    logic [511:0] rx_data = '0;
    logic         rd_v = 1'b0, wr_v = 1'b0, cg_v = 1'b0, c1_wr_v = 1'b0, c0_af = 1'b0, c1_af = 1'b0;
    logic [60:0]  c0_hdr, c1_hdr;
    logic [511:0] c1_data;
    logic         c0_v, c1_v, c1_ir;

    int checks = 0, errors = 0, cyc = 0, wr_cnt = 0, wr_cyc = 0, budget = 0, mode = 0;
    bit auto_wr = 1'b1, rev = 1'b0, cg_pend = 1'b0;
    logic [31:0] rsp_pat = '0, cg_d = '0;
    logic [13:0] cg_a = '0;
    logic [60:0] rd_hdr[$];
    int          rd_cyc[$];
    logic [13:0] pend[$];
    logic [60:0] wr_hdr = '0;
    logic [511:0] wr_data = '0;
    vec_t vecs[6];

    cci_afu_rd_engine dut (
        .vl_clk_LPdomain_32ui              (clk),
        .ffs_vl_LP32ui_lp2sy_SystemReset_n (rst_n),
        .ffs_vl_LP32ui_lp2sy_InitDnForSys  (init),
        .ffs_vl18_LP32ui_lp2sy_C0RxHdr     (rx_hdr),
        .ffs_vl512_LP32ui_lp2sy_C0RxData   (rx_data),
        .ffs_vl_LP32ui_lp2sy_C0RxRdValid   (rd_v),
        .ffs_vl_LP32ui_lp2sy_C0RxWrValid   (wr_v),
        .ffs_vl_LP32ui_lp2sy_C0RxCgValid   (cg_v),
        .ffs_vl_LP32ui_lp2sy_C1RxWrValid   (c1_wr_v),
        .ffs_vl_LP32ui_lp2sy_C0TxAlmFull   (c0_af),
        .ffs_vl_LP32ui_lp2sy_C1TxAlmFull   (c1_af),
        .ffs_vl61_LP32ui_sy2lp_C0TxHdr     (c0_hdr),
        .ffs_vl_LP32ui_sy2lp_C0TxRdValid   (c0_v),
        .ffs_vl61_LP32ui_sy2lp_C1TxHdr     (c1_hdr),
        .ffs_vl512_LP32ui_sy2lp_C1TxData   (c1_data),
        .ffs_vl_LP32ui_sy2lp_C1TxWrValid   (c1_v),
        .ffs_vl_LP32ui_sy2lp_C1TxIrValid   (c1_ir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    function automatic logic [511:0] line_for(input logic [13:0] md);
        return mode == 1 ? (md == 14'd0 ? {16{32'hA5A5A5A5}} : {16{32'h0F0F0F0F}}) : {480'b0, rsp_pat};
    endfunction

    function automatic logic [31:0] exp_ck(input vec_t v);
`ifdef CCI_RD_ENGINE_CKSUM_EN
        return v.ck;
`else
        return v.ck & 32'h0;
`endif
    endfunction

    // One clock: sample outputs at the falling edge, then set up pulse inputs for the next rising edge.
    task automatic tick();
        logic [13:0] md;
        @(negedge clk);
        cyc++;
        if (c0_v) begin
            rd_hdr.push_back(c0_hdr);
            rd_cyc.push_back(cyc);
            pend.push_back(c0_hdr[13:0]);
        end
        cg_v = 1'b0;
        rd_v = 1'b0;
        wr_v = 1'b0;
        c1_wr_v = 1'b0;
        if (c1_v) begin
            wr_cnt++;
            wr_hdr = c1_hdr;
            wr_data = c1_data;
            wr_cyc = cyc;
            c1_wr_v = auto_wr;
        end
        if (cg_pend) begin
            cg_v = 1'b1;
            rx_hdr = {4'h0, cg_a};
            rx_data = {480'b0, cg_d};
            cg_pend = 1'b0;
        end else if (pend.size() > 0 && budget > 0) begin
            md = rev ? pend.pop_back() : pend.pop_front();
            budget--;
            rd_v = 1'b1;
            rx_hdr = {4'h4, md};
            rx_data = line_for(md);
        end
    endtask

    task automatic csr(input logic [13:0] a, input logic [31:0] d);
        cg_a = a;
        cg_d = d;
        cg_pend = 1'b1;
        tick();
    endtask

    task automatic clear_logs();
        rd_hdr.delete();
        rd_cyc.delete();
        pend.delete();
        wr_cnt = 0;
    endtask

    task automatic start(input vec_t v, output int s);
        csr(A_STAT, v.stat);
        csr(A_BASE, v.base);
        csr(A_N, {16'b0, v.n});
        rsp_pat = v.pat;
        csr(A_CTL, 32'd1);
        s = cyc;
    endtask

    task automatic wait_wr();
        for (int k = 0; k < 500 && wr_cnt == 0; k++) tick();
    endtask

    task automatic wait_rd(input int n);
        for (int k = 0; k < 100 && rd_hdr.size() < n; k++) tick();
    endtask

    task automatic check_run(input vec_t v, input int s, input bit timing);
        int bad = 0, bad_t = 0;
        logic [31:0] a;
        logic [13:0] m;
        chk("rd_count", rd_hdr.size(), v.n);
        for (int k = 0; k < rd_hdr.size(); k++) begin
            a = v.base + 32'(k);
            m = 14'(k);
            if (rd_hdr[k] !== {5'b0, 4'h4, 6'b0, a, m}) bad++;
            if (timing && rd_cyc[k] != s + 2 + k) bad_t++;
        end
        chk("rd_hdr_bad", bad, 0);
        if (timing) chk("rd_timing_bad", bad_t, 0);
        if (v.n == 0) chk("n0_latency_ok", wr_cyc - s <= 3, 1);
        chk("wr_count", wr_cnt, 1);
        chk("wr_hdr", wr_hdr, {5'b0, 4'h2, 6'b0, v.stat, 14'h3FFF});
        chk("wr_d0", wr_data[31:0], 1);
        chk("wr_n", wr_data[63:32], v.n);
        chk("wr_ck", wr_data[95:64], exp_ck(v));
        chk("wr_hi_zero", |wr_data[511:96], 0);
    endtask

    task automatic run(input vec_t v);
        int s;
        clear_logs();
        budget = 1000000;
        mode = 0;
        rev = 1'b0;
        start(v, s);
        wait_wr();
        check_run(v, s, 1'b1);
        repeat (3) tick();
    endtask

    initial begin
        int s, r, c;
        vec_t v;
        vecs[0] = '{32'h00001000, 32'h00002000, 16'd4,  32'h00000000, 32'h00000000};
        vecs[1] = '{32'hFFFFFFFE, 32'h00000030, 16'd3,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{32'h00000000, 32'h00000040, 16'd0,  32'h00000000, 32'h00000000};
        vecs[3] = '{32'h00005555, 32'h00000077, 16'd35, 32'h00000001, 32'h00000001};
        vecs[4] = '{32'h00000123, 32'h00000456, 16'd1,  32'h12345678, 32'h12345678};
        vecs[5] = '{32'h00000800, 32'h00000900, 16'd2,  32'hCAFEF00D, 32'h00000000};

        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_c0v", c0_v, 0);
        chk("rst_c1v", c1_v, 0);
        chk("rst_ir", c1_ir, 0);
        chk("rst_c0hdr", c0_hdr, 0);
        chk("rst_c1hdr", c1_hdr, 0);
        chk("rst_c1data", |c1_data, 0);

        foreach (vecs[i]) run(vecs[i]);

        // 40 lines with responses withheld: the window caps at 32 in flight
        v = '{32'h00002000, 32'h00003000, 16'd40, 32'h0, 32'h0};
        clear_logs();
        budget = 0;
        start(v, s);
        repeat (60) tick();
        chk("win_cap", rd_hdr.size(), 32);
        c = 0;
        for (int k = 0; k < 32; k++) if (rd_cyc[k] != s + 2 + k) c++;
        chk("win_timing_bad", c, 0);
        csr(A_N, 32'd5);
        csr(A_BASE, 32'h0);
        csr(A_CTL, 32'd1);
        repeat (5) tick();
        chk("win_restart_ignored", rd_hdr.size(), 32);
        budget = 1;
        tick();
        r = cyc;
        repeat (8) tick();
        chk("win_33rd", rd_hdr.size(), 33);
        chk("win_33rd_after_rsp", rd_cyc[32] > r, 1);
        budget = 1000000;
        wait_wr();
        check_run(v, s, 1'b0);
        repeat (3) tick();

        // almost-full held for 10 cycles mid-run
        v = '{32'h00040000, 32'h00000050, 16'd20, 32'h3, 32'h0};
        clear_logs();
        budget = 1000000;
        start(v, s);
        wait_rd(5);
        c0_af = 1'b1;
        c = rd_hdr.size();
        repeat (10) tick();
        chk("af_blocked", rd_hdr.size() - c, 0);
        c0_af = 1'b0;
        wait_wr();
        check_run(v, s, 1'b0);
        repeat (3) tick();

        // full-line patterns answered out of order: even XOR counts cancel
        v = '{32'h00000700, 32'h00000800, 16'd2, 32'h0, 32'h0};
        clear_logs();
        budget = 0;
        mode = 1;
        rev = 1'b1;
        start(v, s);
        wait_rd(2);
        budget = 2;
        wait_wr();
        check_run(v, s, 1'b1);
        mode = 0;
        rev = 1'b0;
        repeat (3) tick();

        // reset while draining aborts the run; stragglers are ignored
        v = '{32'h00009000, 32'h0000A000, 16'd8, 32'h0, 32'h0};
        clear_logs();
        budget = 0;
        start(v, s);
        wait_rd(8);
        chk("drain_reads", rd_hdr.size(), 8);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2_c0v", c0_v, 0);
        chk("rst2_c1v", c1_v, 0);
        chk("rst2_c0hdr", c0_hdr, 0);
        chk("rst2_c1hdr", c1_hdr, 0);
        budget = 1000000;
        repeat (15) tick();
        chk("stale_sent", pend.size(), 0);
        chk("stale_no_wr", wr_cnt, 0);
        clear_logs();
        csr(14'h1A2, 32'd7);
        csr(A_CTL, 32'd1);
        s = cyc;
        wait_wr();
        chk("rst_csr_no_reads", rd_hdr.size(), 0);
        chk("rst_csr_n", wr_data[63:32], 0);
        chk("rst_csr_stat", wr_hdr[45:14], 0);
        chk("rst_csr_lat_ok", wr_cyc - s <= 3, 1);
        repeat (3) tick();
        run('{32'h00000100, 32'h00000200, 16'd3, 32'h00000007, 32'h00000007});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
